systola_skew_feeder: RTL and testbench

Input staging block that sits directly upstream of the PE array. It accepts one activation vector (ROWS lanes) and one weight vector (COLS lanes) per beat over a valid/ready handshake. It applies the diagonal skew a systolic array requires: lane k is delayed k cycles. It drives the array's `fire`, `in_a` and `in_w` inputs, zero-fills stalls and the end-of-tile drain, then pulses `done` once the last product has reached the far-corner PE.

---
 rtl/systola_skew_feeder.sv | 180 ++++++++++++++++++
 tb/tb_systola_skew_feeder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/systola_skew_feeder.sv
// -----------------------------------------------------------------------------
// systola_skew_feeder
//
// Input staging block placed directly in front of the PE array. It accepts one
// activation vector (ROWS lanes) and one weight vector (COLS lanes) per beat
// over a valid/ready handshake. Each lane is then delayed by its index, which
// gives the diagonal wavefront a systolic array needs. Once the last beat of a
// tile is in, zeros are shifted through every lane until the final product has
// reached the far-corner PE. The block then pulses done for one cycle.
//
// Parameters
//   ROWS  activation lanes (array rows)
//   COLS  weight lanes (array columns)
//   DW    lane width in bits
//
// Ports
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset
//   s_valid  upstream beat valid
//   s_ready  feeder can accept a beat (depends only on state)
//   s_last   marks the final beat of a tile
//   s_a      activation vector, lane 0 in bits [0:DW-1]
//   s_w      weight vector, same lane ordering
//   in_a     skewed activations to the array, same ordering
//   in_w     skewed weights to the array, same ordering
//   fire     array accumulate enable (registered)
//   done     one-cycle pulse: tile fully accumulated
// -----------------------------------------------------------------------------
module systola_skew_feeder #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  input  logic [0:DW*ROWS-1]   s_a,
  input  logic [0:DW*COLS-1]   s_w,
  output logic [0:DW*ROWS-1]   in_a,
  output logic [0:DW*COLS-1]   in_w,
  output logic                 fire,
  output logic                 done
);

  // Number of zero-shift cycles after the last beat: enough for the final
  // beat to cross the deepest activation lane and the deepest weight lane and
  // meet at the far-corner PE.
  localparam int FLUSH_LEN = ROWS + COLS - 2;
  localparam int CW        = (ROWS + COLS - 1 > 1) ? $clog2(ROWS + COLS - 1) : 1;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   flush_cnt_reg;
  logic            fire_reg;
  logic            done_reg;

  logic            accept;
  logic            shift_en;

  // Ready is decoded from the state alone. It is also gated by reset, so the
  // upstream side sees "not ready" while the block is held in reset.
  assign s_ready = rstn && ((state_reg == IDLE) || (state_reg == RUN));
  assign accept  = s_valid && s_ready;

  // Chains move on every RUN/FLUSH cycle. They also move on the accepting
  // edge out of IDLE, so the first beat is captured. In IDLE without an
  // accept, and in DONE, every chain holds zeros, so holding is harmless.
  assign shift_en = accept || (state_reg == RUN) || (state_reg == FLUSH);

  assign fire = fire_reg;
  assign done = done_reg;

  // ---------------------------------------------------------------------------
  // Control FSM. fire/done are registered from the state being entered, so
  // they line up with the lane-0 output register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= '0;
      fire_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      fire_reg <= 1'b0;
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            fire_reg <= 1'b1;
            if (s_last) begin
              state_reg     <= FLUSH;
              flush_cnt_reg <= FLUSH_LOAD;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          // A stall keeps fire high: the bubble is a zero product.
          fire_reg <= 1'b1;
          if (accept && s_last) begin
            state_reg     <= FLUSH;
            flush_cnt_reg <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (flush_cnt_reg != '0) begin
            flush_cnt_reg <= flush_cnt_reg - CW'(1);
            fire_reg      <= 1'b1;
          end else begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Activation skew lines: lane r is r+1 registers deep, so a value accepted
  // at edge E reaches the output after edge E+r.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_a_lane
      logic [DW-1:0] sr_reg [0:gi];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k <= gi; k++) begin
            sr_reg[k] <= '0;
          end
        end else if (shift_en) begin
          sr_reg[0] <= accept ? s_a[gi*DW +: DW] : '0;
          for (int k = 1; k <= gi; k++) begin
            sr_reg[k] <= sr_reg[k-1];
          end
        end
      end

      assign in_a[gi*DW +: DW] = sr_reg[gi];
    end

    // Weight skew lines: lane c is c+1 registers deep.
    for (gi = 0; gi < COLS; gi++) begin : g_w_lane
      logic [DW-1:0] sr_reg [0:gi];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k <= gi; k++) begin
            sr_reg[k] <= '0;
          end
        end else if (shift_en) begin
          sr_reg[0] <= accept ? s_w[gi*DW +: DW] : '0;
          for (int k = 1; k <= gi; k++) begin
            sr_reg[k] <= sr_reg[k-1];
          end
        end
      end

      assign in_w[gi*DW +: DW] = sr_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_systola_skew_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for systola_skew_feeder (4x4, 8-bit lanes).
// A timing-rule reference model records every accepted beat by edge index.
// After each edge it pushes the expected output set for the following cycle
// onto a queue. A negedge monitor pops each entry and compares it with the
// DUT outputs. Reset checks are made directly against constant zeros.
// -----------------------------------------------------------------------------
module tb_systola_skew_feeder;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int AW   = DW * ROWS;
  localparam int WW   = DW * COLS;
  localparam int RC   = ROWS + COLS;
  localparam int HMAX = 1024;

  logic            clk;
  logic            rstn;
  logic            s_valid;
  logic            s_ready;
  logic            s_last;
  logic [0:AW-1]   s_a;
  logic [0:WW-1]   s_w;
  logic [0:AW-1]   in_a;
  logic [0:WW-1]   in_w;
  logic            fire;
  logic            done;

  systola_skew_feeder #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_a     (s_a),
    .s_w     (s_w),
    .in_a    (in_a),
    .in_w    (in_w),
    .fire    (fire),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            t;
    logic [0:AW-1] a;
    logic [0:WW-1] w;
    logic          fire;
    logic          done;
    logic          ready;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  int            t      = 0;    // edge index of the next modelled edge
  int            tmin   = 0;    // beats before this edge were wiped by reset
  int            e0     = -1;   // first accept edge of the current tile
  int            el     = -1;   // last accept edge of the current tile
  logic          m_ready = 1'b0;
  bit            acc    [0:HMAX-1];
  logic [0:AW-1] hist_a [0:HMAX-1];
  logic [0:WW-1] hist_w [0:HMAX-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [0:AW-1] pk(input logic [7:0] l0, input logic [7:0] l1,
                                       input logic [7:0] l2, input logic [7:0] l3);
    return {l0, l1, l2, l3};
  endfunction

  // Drive one beat's inputs, step across an edge, and push the model's
  // expectation for the cycle that follows that edge.
  task automatic cycle(input logic v, input logic l, input logic [0:AW-1] a, input logic [0:WW-1] w);
    exp_t e;
    s_valid = v;
    s_last  = l;
    s_a     = a;
    s_w     = w;
    @(posedge clk);
    acc[t] = v && m_ready;
    if (acc[t]) begin
      hist_a[t] = a;
      hist_w[t] = w;
      if (e0 < 0) e0 = t;
      if (l) el = t;
    end
    e.t = t;
    e.a = '0;
    e.w = '0;
    for (int r = 0; r < ROWS; r++)
      if (t - r >= tmin && acc[t-r]) e.a[r*DW +: DW] = hist_a[t-r][r*DW +: DW];
    for (int c = 0; c < COLS; c++)
      if (t - c >= tmin && acc[t-c]) e.w[c*DW +: DW] = hist_w[t-c][c*DW +: DW];
    e.fire  = (e0 >= 0) && (t >= e0) && ((el < 0) || (t <= el + RC - 2));
    e.done  = (el >= 0) && (t == el + RC - 1);
    m_ready = !((el >= 0) && (t >= el) && (t <= el + RC - 1));
    e.ready = m_ready;
    if ((el >= 0) && (t >= el + RC - 1)) begin
      e0 = -1;
      el = -1;
    end
    t++;
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0);
  endtask

  // Assert reset off the clock edge, check that outputs clear at once, hold
  // for some edges, then release and restart the model.
  task automatic do_reset(input int hold);
    q.delete();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rstn    = 1'b0;
    #1;
    check("rst_in_a",  64'(in_a),   64'd0);
    check("rst_in_w",  64'(in_w),   64'd0);
    check("rst_fire",  64'(fire),   64'd0);
    check("rst_done",  64'(done),   64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    repeat (hold) @(posedge clk);
    #1;
    rstn    = 1'b1;
    e0      = -1;
    el      = -1;
    m_ready = 1'b1;
    tmin    = t;
  endtask

  always @(negedge clk) begin
    if (rstn && q.size() > 0) begin
      mon_e = q.pop_front();
      $display("cyc %0d: in_a=%h in_w=%h fire=%b done=%b ready=%b", mon_e.t, in_a, in_w, fire, done, s_ready);
      check($sformatf("in_a@%0d", mon_e.t),  64'(in_a),    64'(mon_e.a));
      check($sformatf("in_w@%0d", mon_e.t),  64'(in_w),    64'(mon_e.w));
      check($sformatf("fire@%0d", mon_e.t),  64'(fire),    64'(mon_e.fire));
      check($sformatf("done@%0d", mon_e.t),  64'(done),    64'(mon_e.done));
      check($sformatf("ready@%0d", mon_e.t), 64'(s_ready), 64'(mon_e.ready));
    end
  end

  initial begin
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_a     = '0;
    s_w     = '0;
    #2;
    do_reset(3);

    // Reset followed by 10 idle cycles.
    idle(10);

    // Single-beat tile.
    cycle(1'b1, 1'b1, pk(8'd1, 8'd2, 8'd3, 8'd4), pk(8'd5, 8'd6, 8'd7, 8'd8));
    idle(10);

    // Four back-to-back beats, last on the fourth.
    for (int b = 1; b <= 4; b++)
      cycle(1'b1, (b == 4), pk(8'(b), 8'(b), 8'(b), 8'(b)), pk(8'(b+16), 8'(b+16), 8'(b+16), 8'(b+16)));
    idle(10);

    // Two-cycle stall in the middle of a tile.
    cycle(1'b1, 1'b0, pk(8'h11, 8'h12, 8'h13, 8'h14), pk(8'h21, 8'h22, 8'h23, 8'h24));
    cycle(1'b1, 1'b0, pk(8'h31, 8'h32, 8'h33, 8'h34), pk(8'h41, 8'h42, 8'h43, 8'h44));
    cycle(1'b0, 1'b0, pk(8'hee, 8'hee, 8'hee, 8'hee), pk(8'hee, 8'hee, 8'hee, 8'hee));
    cycle(1'b0, 1'b0, pk(8'hee, 8'hee, 8'hee, 8'hee), pk(8'hee, 8'hee, 8'hee, 8'hee));
    cycle(1'b1, 1'b0, pk(8'h51, 8'h52, 8'h53, 8'h54), pk(8'h61, 8'h62, 8'h63, 8'h64));
    cycle(1'b1, 1'b1, pk(8'h71, 8'h72, 8'h73, 8'h74), pk(8'h81, 8'h82, 8'h83, 8'h84));
    idle(10);

    // s_valid held high through FLUSH/DONE: each beat is a single-beat tile
    // and must only be taken when ready. Data changes every cycle, so any
    // wrongly accepted beat shows up on the lanes.
    for (int i = 0; i < 22; i++)
      cycle(1'b1, 1'b1, pk(8'(i+1), 8'(i+33), 8'(i+65), 8'(i+97)),
            pk(8'($urandom_range(1, 255)), 8'(i+129), 8'(i+161), 8'(i+193)));
    idle(10);

    // Reset two cycles into FLUSH: tile abandoned, no done.
    cycle(1'b1, 1'b0, pk(8'ha1, 8'ha2, 8'ha3, 8'ha4), pk(8'hb1, 8'hb2, 8'hb3, 8'hb4));
    cycle(1'b1, 1'b1, pk(8'hc1, 8'hc2, 8'hc3, 8'hc4), pk(8'hd1, 8'hd2, 8'hd3, 8'hd4));
    cycle(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    do_reset(2);
    idle(10);

    // New single-beat tile after the mid-flush reset.
    cycle(1'b1, 1'b1, pk(8'd1, 8'd2, 8'd3, 8'd4), pk(8'd5, 8'd6, 8'd7, 8'd8));
    idle(10);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
